// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder family:
// slice width, stage-count helper and the per-bit propagate/generate pair.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

    function automatic int cla_stages(input int width, input int gps);
        return width / (CLA_GROUP_W * gps);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice. Exposes group P/G and the carry
// into bit 3 so the top slice can form the signed-overflow flag.
module cla4_slice
    import cla_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4,
    output logic       p4,
    output logic       g4
);

    cla_pg_t [3:0] pg;
    logic          c1;
    logic          c2;

    always_comb begin
        pg = '0;
        for (int i = 0; i < 4; i++) begin
            pg[i].p = a[i] ^ b[i];
            pg[i].g = a[i] & b[i];
        end
    end

    assign c1 = pg[0].g | (pg[0].p & c0);
    assign c2 = pg[1].g | (pg[1].p & pg[0].g) | (pg[1].p & pg[0].p & c0);
    assign c3 = pg[2].g | (pg[2].p & pg[1].g) | (pg[2].p & pg[1].p & pg[0].g)
              | (pg[2].p & pg[1].p & pg[0].p & c0);

    assign g4 = pg[3].g | (pg[3].p & pg[2].g) | (pg[3].p & pg[2].p & pg[1].g)
              | (pg[3].p & pg[2].p & pg[1].p & pg[0].g);
    assign p4 = pg[3].p & pg[2].p & pg[1].p & pg[0].p;
    assign c4 = g4 | (p4 & c0);

    assign s = {pg[3].p ^ c3, pg[2].p ^ c2, pg[1].p ^ c1, pg[0].p ^ c0};

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: GPS 4-bit slices per stage,
// registered group carry between stages, skewed operands, deskewed sums.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW     = CLA_GROUP_W * GPS;
    localparam int STAGES = cla_stages(WIDTH, GPS);

    if (GPS < 1 || WIDTH < SW || (WIDTH % SW) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*GPS");
    end

    logic              en;
    logic              acc;
    logic              out_load;
    logic              last_vld_in;
    logic              c_in;
    logic [WIDTH-1:0]  beff;
    logic [STAGES-1:0] vld_p;

    // A held output stalls the whole pipe; in_ready follows out_ready combinationally.
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en && rst_n;
    assign acc       = in_valid && in_ready;
    assign out_valid = vld_p[STAGES-1];
    assign out_load  = en && last_vld_in;

    assign beff = sub ? ~b : b;
    assign c_in = sub | cin;

    if (STAGES == 1) begin : g_last_vld
        assign last_vld_in = acc;
    end else begin : g_last_vld
        assign last_vld_in = vld_p[STAGES-2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (en) begin
            vld_p[0] <= acc;
            for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int L = STAGES - k;

        logic [SW-1:0]  op_a;
        logic [SW-1:0]  op_b;
        logic [SW-1:0]  s_comb;
        logic           st_cin;
        logic           st_cout;
        logic [GPS:0]   cc;
        logic [GPS-1:0] p4_v;
        logic [GPS-1:0] g4_v;
        logic [GPS-1:0] c3_v;
        logic           unused_bits;

        // Stage boundary: operand skew (k cycles) and incoming group carry
        if (k == 0) begin : g_op
            assign op_a   = a[0 +: SW];
            assign op_b   = beff[0 +: SW];
            assign st_cin = c_in;
        end else begin : g_op
            logic [SW-1:0] a_sk [k];
            logic [SW-1:0] b_sk [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < k; i++) begin
                        a_sk[i] <= '0;
                        b_sk[i] <= '0;
                    end
                end else if (en) begin
                    a_sk[0] <= a[k*SW +: SW];
                    b_sk[0] <= beff[k*SW +: SW];
                    for (int i = 1; i < k; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end

            assign op_a   = a_sk[k-1];
            assign op_b   = b_sk[k-1];
            assign st_cin = g_stage[k-1].g_carry.carry_q;
        end

        assign cc[0] = st_cin;
        for (genvar j = 0; j < GPS; j++) begin : g_slice
            cla4_slice u_slice (
                .a  (op_a[4*j +: 4]),
                .b  (op_b[4*j +: 4]),
                .c0 (cc[j]),
                .s  (s_comb[4*j +: 4]),
                .c3 (c3_v[j]),
                .c4 (cc[j+1]),
                .p4 (p4_v[j]),
                .g4 (g4_v[j])
            );
        end

        // Stage carry-out from the group generate/propagate terms
        always_comb begin
            st_cout = st_cin;
            for (int j = 0; j < GPS; j++) st_cout = g4_v[j] | (p4_v[j] & st_cout);
        end

        assign unused_bits = ^{cc[GPS], c3_v};

        if (k < STAGES - 1) begin : g_carry
            logic carry_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  carry_q <= 1'b0;
                else if (en) carry_q <= st_cout;
            end
        end else begin : g_flags
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (out_load) begin
                    cout <= st_cout;
                    ovf  <= st_cout ^ c3_v[GPS-1];
                end
            end
        end

        // Stage boundary: result deskew; last register only loads valid results
        if (L == 1) begin : g_deskew
            logic [SW-1:0] res_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)        res_q <= '0;
                else if (out_load) res_q <= s_comb;
            end
            assign sum[k*SW +: SW] = res_q;
        end else begin : g_deskew
            logic [SW-1:0] res_q [L];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < L; d++) res_q[d] <= '0;
                end else if (en) begin
                    res_q[0] <= s_comb;
                    for (int d = 1; d < L - 1; d++) res_q[d] <= res_q[d-1];
                    if (last_vld_in) res_q[L-1] <= res_q[L-2];
                end
            end
            assign sum[k*SW +: SW] = res_q[L-1];
        end
    end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's 4-bit CLA.
- WIDTH is split into 4-bit lookahead slices. Each pipeline stage holds GPS slices, and the group carry is registered between stages.
- It has a valid/ready stream interface and an add/subtract mode, and produces a signed-overflow flag.
- It sits in the datapath wherever a wide, high-Fmax adder with a throughput of one result per cycle is needed.

Parameters:
- WIDTH, 16: operand width. Must be a multiple of 4*GPS; elaboration fails otherwise.
- GPS, 1: number of 4-bit slices per pipeline stage.
- STAGES, derived as WIDTH/(4*GPS): number of pipeline stages. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input operands are valid
- in_ready  out  1  block can accept an input this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in. Ignored when sub=1.
- sub  in  1  1 selects A-B, 0 selects A+B+cin
- out_valid  out  1  result is valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB. In subtract mode this is the not-borrow.
- ovf  out  1  two's-complement overflow

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits, the skew/deskew registers, the inter-stage carries, sum, cout and ovf clear to 0 immediately.
  - in_ready is 1 while rst_n=1 and the pipe is not stalled.
- Effective operands:
  - beff = sub ? ~b : b
  - c_in = sub ? 1 : cin
- Stage k (0..STAGES-1):
  - Adds bits [4*GPS*k +: 4*GPS] using GPS chained cla4_slice instances. Carry into stage k is the registered carry out of stage k-1; c_in for stage 0.
- Skew registers: operand bits for stage k are delayed k cycles. sub is not needed past stage 0.
- Deskew registers: result bits from stage k are delayed STAGES-1-k cycles, so that all sum bits emerge aligned.
- Final stage registers:
  - sum
  - cout = carry out of bit WIDTH-1
  - ovf = carry into bit WIDTH-1 XOR cout
- Timing:
  - Latency is exactly STAGES cycles from an accepted input (in_valid & in_ready at edge) to out_valid=1 with that result.
  - Throughput is one result per cycle.
- Global enable:
  - en = !(out_valid & !out_ready)
  - in_ready = en
  - When en=0, every stage register holds its value. When en=1, all stages advance together.
- Bubbles:
  - A cycle without an accepted input inserts a bubble (stage valid=0). Bubbles advance with the pipe and are not collapsed.
  - Data registers may load garbage with valid=0. sum/cout/ovf hold their last value while out_valid=0.
- Ordering: results leave in acceptance order, with no loss or duplication.
- Simultaneous events:
  - Pipe full, out_valid=1, and out_ready rises: the output transfers and a new input is accepted in the same cycle.
  - in_valid=1 while in_ready=0: not accepted. The source must hold its inputs.
- Reset mid-operation: all in-flight results are discarded. out_valid=0 until new inputs have traversed the pipe.
- STAGES=1 (e.g. WIDTH=4): single register stage, latency 1, no skew/deskew logic generated.
- out_valid does not depend combinationally on out_ready. in_ready does depend combinationally on out_ready.

Decomposition:
- cla_pkg:
  - localparam CLA_GROUP_W=4
  - function cla_stages(width, gps) returning width/(4*gps)
  - struct cla_pg_t {p, g}
- Sub-module cla4_slice (combinational):
  - Inputs: a[3:0], b[3:0], c0.
  - Outputs: s[3:0], c4, group propagate p4, group generate g4.
  - Also exposes c3, needed for ovf in the top slice.
- Top level: generate loops for stages and slices, skew/deskew shift registers, valid pipe and enable.

Test Plan:
- Reset and basic add (WIDTH=16, GPS=1, STAGES=4):
  - Hold rst_n=0: out_valid=0, sum=0, cout=0, ovf=0.
  - Release, then apply 0x0000+0x0001, cin=0: out_valid=1 exactly 4 cycles later, sum=0x0001, cout=0, ovf=0.
- Full carry ripple across all stages:
  - 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract mode (sub=1):
  - 0x0005-0x0007 with cin=0 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back random operands and hold out_ready=0 for 3 cycles mid-stream.
  - in_ready drops in the same cycle the stall starts.
  - All 8 results arrive in order and match a reference model, with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 results in flight.
  - out_valid=0 immediately.
  - After release, only post-reset inputs appear, at 4-cycle latency.
- Single-stage configuration (WIDTH=4, GPS=1):
  - 1010+0111, cin=1 -> sum=0010, cout=1, with latency 1.
  - 1111+0001 -> sum=0000, cout=1.
